instr_fetch_unit: RTL and testbench
===================================

Name: instr_fetch_unit

Overview:
- Requester side of the instruction memory interface. Owns the PC, drives the byte address to instruction memory, and waits a fixed read latency. It then captures the 32-bit instruction word and hands it to decode over a valid/ready handshake.
- Supports branch redirect from execute and stops at the end of the program image.
- Sits between instruction memory and the decode stage of the processor.

Parameters:
RESET_PC, 32'd0, byte address of the first fetch after reset
MEM_SIZE, 40, program image size in bytes; fetch stops at PC >= MEM_SIZE
RD_WAIT, 2, clock cycles the memory address must be held stable before the instruction is sampled (minimum 1)

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
enable  input  1  permits issuing new fetches
mem_addr  output  32  byte address to instruction memory
mem_instr  input  32  instruction word from memory (combinational in mem_addr)
instr_out  output  32  captured instruction to decode
pc_out  output  32  byte address of instr_out
instr_valid  output  1  instr_out/pc_out valid
instr_ready  input  1  decode accepts instr_out this cycle
redirect  input  1  branch taken; load redirect_addr
redirect_addr  input  32  branch target byte address
fetch_done  output  1  PC has passed the end of the program image (sticky)
align_err  output  1  misaligned redirect target (sticky)

Behaviour:
- Reset (rst_n=0, asynchronous):
  - pc=RESET_PC, mem_addr=RESET_PC.
  - instr_out=0, pc_out=0.
  - instr_valid=0, fetch_done=0, align_err=0.
  - Wait counter=0, state=IDLE.
- States: IDLE, ISSUE, WAIT, HOLD, DONE, ERR.
- mem_addr always equals pc. It changes only on a pc update, never while in WAIT.
- IDLE: enable=1 -> ISSUE; otherwise stay.
- ISSUE (1 cycle):
  - If pc >= MEM_SIZE -> DONE with fetch_done=1.
  - Otherwise load wait counter with RD_WAIT-1 -> WAIT.
- WAIT:
  - Decrement counter each cycle.
  - In the cycle the counter is 0: instr_out<=mem_instr, pc_out<=pc, pc<=pc+4, instr_valid<=1 -> HOLD.
- Latency: instr_valid rises RD_WAIT+1 cycles after entry to ISSUE.
- HOLD:
  - instr_valid, instr_out and pc_out are held stable until instr_ready=1.
  - On the handshake cycle (valid & ready), instr_valid<=0 next cycle.
  - Next state is ISSUE if enable=1, else IDLE.
- Throughput: at most one instruction per RD_WAIT+2 cycles. There are no back-to-back fetches.
- enable deasserted mid-fetch: the current fetch completes to HOLD. No new ISSUE occurs.
- DONE: fetch_done=1 and no fetches until redirect or reset.
- redirect=1 (any state except ERR; highest priority after reset):
  - Next cycle pc<=redirect_addr and instr_valid<=0.
  - Any in-flight or held instruction is discarded. Redirect wins over a same-cycle handshake; decode flushes on redirect.
  - fetch_done<=0, counter cleared.
  - Next state is ISSUE if enable=1, else IDLE.
- Misaligned redirect: if redirect_addr[1:0]!=0, then align_err<=1, pc unchanged, instr_valid<=0 -> ERR. ERR is left only by reset.
- Arithmetic:
  - pc+4 is 32-bit modulo.
  - The MEM_SIZE comparison is unsigned on the full 32-bit pc.
  - pc_out always carries the pre-increment address.
- Reset mid-WAIT or mid-HOLD: all outputs return to reset values immediately. Fetch restarts at RESET_PC.

Test Plan:
- Reset then enable=1, instr_ready=1, memory image 0x58000001 @0, 0x58080002 @4: instr_valid first rises 3 cycles after ISSUE with instr_out=0x58000001, pc_out=0. Next word has pc_out=4, 4 cycles later.
- Backpressure: hold instr_ready=0 for 5 cycles in HOLD -> instr_out/pc_out unchanged and mem_addr=pc_out+4 stable. No new fetch until the ready cycle.
- End of image, MEM_SIZE=40: run freely -> last pc_out=36, then fetch_done=1, instr_valid stays 0, mem_addr=40.
- Redirect during WAIT to 0x8, and redirect during HOLD with instr_ready=1 in the same cycle: discarded word is never seen; next valid has pc_out=8 and instr_out equal to the word at 8. fetch_done is cleared if it was set.
- Misaligned redirect_addr=0x6: align_err=1, no further instr_valid, enable toggling has no effect, rst_n pulse clears align_err.
- Async reset asserted mid-WAIT between clock edges: outputs clear before the next edge. After release, the first fetch is at RESET_PC.

Source files
------------

// File: rtl/instr_fetch_unit.sv
// Instruction fetch requester: owns the PC, waits RD_WAIT cycles on instruction memory,
// and hands captured words to decode over valid/ready. Handles redirects and end of image.
module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'd0,
    parameter logic [31:0] MEM_SIZE = 32'd40,
    parameter int unsigned RD_WAIT  = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        enable,
    output logic [31:0] mem_addr,
    input  logic [31:0] mem_instr,
    output logic [31:0] instr_out,
    output logic [31:0] pc_out,
    output logic        instr_valid,
    input  logic        instr_ready,
    input  logic        redirect,
    input  logic [31:0] redirect_addr,
    output logic        fetch_done,
    output logic        align_err
);

    localparam int unsigned CW = (RD_WAIT > 1) ? $clog2(RD_WAIT) : 1;

    typedef enum logic [2:0] {
        StIdle,
        StIssue,
        StWait,
        StHold,
        StDone,
        StErr
    } state_e;

    state_e        state;
    logic [31:0]   pc;
    logic [CW-1:0] wait_cnt;

    // Memory sees the PC directly; pc only moves on capture or redirect, never mid-wait.
    assign mem_addr = pc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= StIdle;
            pc          <= RESET_PC;
            wait_cnt    <= '0;
            instr_out   <= '0;
            pc_out      <= '0;
            instr_valid <= 1'b0;
            fetch_done  <= 1'b0;
            align_err   <= 1'b0;
        end else if (redirect && (state != StErr)) begin
            instr_valid <= 1'b0;
            wait_cnt    <= '0;
            if (redirect_addr[1:0] != 2'b00) begin
                align_err <= 1'b1;
                state     <= StErr;
            end else begin
                pc         <= redirect_addr;
                fetch_done <= 1'b0;
                state      <= enable ? StIssue : StIdle;
            end
        end else begin
            case (state)
                StIdle: begin
                    if (enable) begin
                        state <= StIssue;
                    end
                end
                StIssue: begin
                    if (pc >= MEM_SIZE) begin
                        fetch_done <= 1'b1;
                        state      <= StDone;
                    end else begin
                        wait_cnt <= CW'(RD_WAIT - 1);
                        state    <= StWait;
                    end
                end
                StWait: begin
                    if (wait_cnt == '0) begin
                        instr_out   <= mem_instr;
                        pc_out      <= pc;
                        pc          <= pc + 32'd4;
                        instr_valid <= 1'b1;
                        state       <= StHold;
                    end else begin
                        wait_cnt <= wait_cnt - CW'(1);
                    end
                end
                StHold: begin
                    if (instr_ready) begin
                        instr_valid <= 1'b0;
                        state       <= enable ? StIssue : StIdle;
                    end
                end
                StDone: ;
                StErr: ;
                default: state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: cycle table for the basic flow, directed corner sequences,
// and a random run checked against a stream-level model of the fetched program.
module tb_instr_fetch_unit;

    localparam logic [31:0] RESET_PC = 32'd0;
    localparam logic [31:0] MEM_SIZE = 32'd40;
    localparam int unsigned RD_WAIT  = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        enable = 1'b0;
    logic [31:0] mem_addr;
    logic [31:0] mem_instr;
    logic [31:0] instr_out;
    logic [31:0] pc_out;
    logic        instr_valid;
    logic        instr_ready = 1'b0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_addr = '0;
    logic        fetch_done;
    logic        align_err;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    function automatic logic [31:0] word_at(input logic [31:0] a);
        return 32'h5800_0001 + (a >> 2) * 32'h0008_0001;
    endfunction

    assign mem_instr = word_at(mem_addr);

    instr_fetch_unit #(
        .RESET_PC(RESET_PC),
        .MEM_SIZE(MEM_SIZE),
        .RD_WAIT (RD_WAIT)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .enable       (enable),
        .mem_addr     (mem_addr),
        .mem_instr    (mem_instr),
        .instr_out    (instr_out),
        .pc_out       (pc_out),
        .instr_valid  (instr_valid),
        .instr_ready  (instr_ready),
        .redirect     (redirect),
        .redirect_addr(redirect_addr),
        .fetch_done   (fetch_done),
        .align_err    (align_err)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_valid"}, instr_valid, 0);
        check({tag, "_pc_out"}, pc_out, 0);
        check({tag, "_instr"}, instr_out, 0);
        check({tag, "_mem_addr"}, mem_addr, RESET_PC);
        check({tag, "_done"}, fetch_done, 0);
        check({tag, "_err"}, align_err, 0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        enable = 1'b0;
        instr_ready = 1'b0;
        redirect = 1'b0;
        redirect_addr = '0;
        repeat (2) step();
        check_reset_state("reset");
        rst_n = 1'b1;
    endtask

    // Steps until instr_valid is seen, bounded; returns edges taken.
    task automatic wait_valid(input int max, output int edges, output bit ok);
        edges = 0;
        while (!instr_valid && edges < max) begin
            step();
            edges++;
        end
        ok = instr_valid;
    endtask

    typedef struct {
        logic        en;
        logic        rdy;
        logic        rd;
        logic [31:0] raddr;
        logic        vld;
        logic [31:0] pco;
        logic [31:0] ins;
        logic [31:0] maddr;
        logic        done;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input logic en, input logic rdy, input logic rd,
                                input logic [31:0] raddr, input logic vld,
                                input logic [31:0] pco, input logic [31:0] ins,
                                input logic [31:0] maddr, input logic done);
        vec_t v;
        v.en = en; v.rdy = rdy; v.rd = rd; v.raddr = raddr;
        v.vld = vld; v.pco = pco; v.ins = ins; v.maddr = maddr; v.done = done;
        return v;
    endfunction

    // Stream-level model: the accepted words must be consecutive from the last redirect.
    logic [31:0] exp_pc;
    int          n_hs;
    bit          prev_hold;
    logic [31:0] prev_pco, prev_ins;

    task automatic model_cycle();
        if (prev_hold) begin
            check("hold_valid", instr_valid, 1);
            check("hold_pc_out", pc_out, prev_pco);
            check("hold_instr", instr_out, prev_ins);
        end
        if (fetch_done) check("done_past_end", exp_pc >= MEM_SIZE, 1);
        if (instr_valid) check("mem_addr_next", mem_addr, pc_out + 32'd4);
        prev_hold = instr_valid && !instr_ready && !redirect;
        prev_pco  = pc_out;
        prev_ins  = instr_out;
        if (redirect) begin
            exp_pc = redirect_addr;
        end else if (instr_valid && instr_ready) begin
            check("stream_pc", pc_out, exp_pc);
            check("stream_instr", instr_out, word_at(exp_pc));
            check("stream_in_image", pc_out < MEM_SIZE, 1);
            exp_pc += 32'd4;
            n_hs++;
        end
        step();
    endtask

    initial begin
        int  edges;
        bit  ok;

        // Basic flow, backpressure, HOLD redirect, enable drop and end of image.
        for (int i = 0; i < 3; i++) tbl.push_back(mk(1, 1, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 1, 0, 0, 1, 0, 32'h5800_0001, 4, 0));
        for (int i = 0; i < 3; i++) tbl.push_back(mk(1, 1, 0, 0, 0, 0, 32'h5800_0001, 4, 0));
        tbl.push_back(mk(1, 1, 0, 0, 1, 4, 32'h5808_0002, 8, 0));
        for (int i = 0; i < 5; i++) tbl.push_back(mk(1, 0, 0, 0, 1, 4, 32'h5808_0002, 8, 0));
        tbl.push_back(mk(1, 1, 0, 0, 0, 4, 32'h5808_0002, 8, 0));
        for (int i = 0; i < 2; i++) tbl.push_back(mk(1, 0, 0, 0, 0, 4, 32'h5808_0002, 8, 0));
        tbl.push_back(mk(1, 0, 0, 0, 1, 8, word_at(8), 12, 0));
        tbl.push_back(mk(1, 1, 1, 32'h20, 0, 8, word_at(8), 32'h20, 0));
        for (int i = 0; i < 2; i++) tbl.push_back(mk(1, 1, 0, 0, 0, 8, word_at(8), 32'h20, 0));
        tbl.push_back(mk(1, 1, 0, 0, 1, 32'h20, word_at(32'h20), 32'h24, 0));
        for (int i = 0; i < 2; i++) tbl.push_back(mk(0, 1, 0, 0, 0, 32'h20, word_at(32'h20), 32'h24, 0));
        for (int i = 0; i < 3; i++) tbl.push_back(mk(1, 1, 0, 0, 0, 32'h20, word_at(32'h20), 32'h24, 0));
        tbl.push_back(mk(1, 1, 0, 0, 1, 32'h24, word_at(32'h24), 32'h28, 0));
        tbl.push_back(mk(1, 1, 0, 0, 0, 32'h24, word_at(32'h24), 32'h28, 0));
        for (int i = 0; i < 2; i++) tbl.push_back(mk(1, 1, 0, 0, 0, 32'h24, word_at(32'h24), 32'h28, 1));

        #1;
        do_reset();
        foreach (tbl[i]) begin
            enable = tbl[i].en;
            instr_ready = tbl[i].rdy;
            redirect = tbl[i].rd;
            redirect_addr = tbl[i].raddr;
            step();
            check($sformatf("tbl%0d_valid", i), instr_valid, tbl[i].vld);
            check($sformatf("tbl%0d_pc_out", i), pc_out, tbl[i].pco);
            check($sformatf("tbl%0d_instr", i), instr_out, tbl[i].ins);
            check($sformatf("tbl%0d_mem_addr", i), mem_addr, tbl[i].maddr);
            check($sformatf("tbl%0d_done", i), fetch_done, tbl[i].done);
        end

        // Redirect out of DONE clears fetch_done; redirect during WAIT discards that word.
        enable = 1; instr_ready = 1; redirect = 1; redirect_addr = 0;
        step();
        check("done_cleared", fetch_done, 0);
        check("redir0_addr", mem_addr, 0);
        redirect = 0;
        step();
        redirect = 1; redirect_addr = 8;
        step();
        redirect = 0;
        check("wait_redir_addr", mem_addr, 8);
        check("wait_redir_valid", instr_valid, 0);
        instr_ready = 0;
        wait_valid(10, edges, ok);
        check("wait_redir_seen", ok, 1);
        check("wait_redir_latency", edges, RD_WAIT + 1);
        check("wait_redir_pc_out", pc_out, 8);
        check("wait_redir_instr", instr_out, word_at(8));

        // Misaligned redirect locks in ERR until reset.
        redirect = 1; redirect_addr = 32'h6;
        step();
        redirect = 0;
        check("misalign_err", align_err, 1);
        check("misalign_valid", instr_valid, 0);
        check("misalign_pc_kept", mem_addr, 12);
        for (int i = 0; i < 8; i++) begin
            enable = i[0];
            instr_ready = 1;
            redirect = (i == 3);
            redirect_addr = 32'h10;
            step();
            check("err_no_valid", instr_valid, 0);
        end
        redirect = 0;
        check("err_sticky", align_err, 1);
        check("err_pc_kept", mem_addr, 12);
        #2 rst_n = 0;
        #1 check("err_async_clear", align_err, 0);
        check("err_async_addr", mem_addr, RESET_PC);
        do_reset();

        // Async reset mid-WAIT and mid-HOLD, away from the clock edge.
        enable = 1; instr_ready = 1; redirect = 1; redirect_addr = 32'h10;
        step();
        redirect = 0;
        wait_valid(10, edges, ok);
        check("pre_rst_seen", ok, 1);
        check("pre_rst_pc_out", pc_out, 32'h10);
        step();
        step();
        check("mid_wait_addr", mem_addr, 32'h14);
        #2 rst_n = 0;
        #1 check_reset_state("async_wait");
        #1 rst_n = 1;
        enable = 1; instr_ready = 0;
        step();
        wait_valid(10, edges, ok);
        check("restart_seen", ok, 1);
        check("restart_latency", edges, RD_WAIT + 1);
        check("restart_pc_out", pc_out, RESET_PC);
        check("restart_instr", instr_out, word_at(RESET_PC));
        #2 rst_n = 0;
        #1 check_reset_state("async_hold");
        do_reset();

        // Random run against the stream model.
        exp_pc = RESET_PC;
        n_hs = 0;
        prev_hold = 0;
        for (int c = 0; c < 1500; c++) begin
            enable = ($urandom_range(0, 9) != 0);
            instr_ready = $urandom_range(0, 1) == 1;
            redirect = ($urandom_range(0, 11) == 0);
            redirect_addr = 32'($urandom_range(0, 12)) << 2;
            model_cycle();
        end
        redirect = 0; enable = 1; instr_ready = 1;
        for (int c = 0; c < 300 && !fetch_done; c++) model_cycle();
        check("drain_done", fetch_done, 1);
        check("drain_end_addr", mem_addr, exp_pc);
        check("drain_past_end", exp_pc >= MEM_SIZE, 1);
        check("drain_no_valid", instr_valid, 0);
        check("random_handshakes", n_hs > 20, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
